// File: rtl/grf.sv
// General register file: 32 x WIDTH, $0 hardwired to zero, two combinational
// read ports with optional same-cycle write bypass, committed-write counter.
module grf #(
    parameter int WIDTH  = 32,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [4:0]       ra1,
    input  logic [4:0]       ra2,
    input  logic [4:0]       wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [31:0]      pc,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic [31:0]      wcnt
);

    logic [WIDTH-1:0] regs [32];
    logic             wr_commit;
    logic             byp_live;

    assign wr_commit = we && !reset && (wa != 5'd0);
    assign byp_live  = (BYPASS != 0) && we && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            wcnt <= '0;
        end else if (wr_commit) begin
            regs[wa] <= wd;
            wcnt     <= wcnt + 32'd1;
`ifndef SYNTHESIS
            $display("@%h: $%d <= %h", pc, wa, wd);
`endif
        end
    end

    // regs[0] is never written, but the ra==0 guard keeps $0 zero even before reset
    always_comb begin
        rd1 = '0;
        if (ra1 != 5'd0) begin
            if (byp_live && (wa == ra1)) begin
                rd1 = wd;
            end else begin
                rd1 = regs[ra1];
            end
        end
    end

    always_comb begin
        rd2 = '0;
        if (ra2 != 5'd0) begin
            if (byp_live && (wa == ra2)) begin
                rd2 = wd;
            end else begin
                rd2 = regs[ra2];
            end
        end
    end

endmodule

// File: doc/grf.md
# grf

General register file for the single-cycle MIPS datapath. It receives the write-back address selected by `Reg_MUX` and the write-back data selected by `Memtoreg`, and serves both operand reads (rs, rt) to the ALU path and `ALU_MUX`. It holds 32 general-purpose registers, with `$0` hardwired to zero. It also emits a per-write trace line and a committed-write counter for verification.

## Interface

Parameters:
- `WIDTH`, default 32: data width of each register.
- `BYPASS`, default 1: when 1, a read of the register being written in the same cycle returns the write data; when 0, it returns the stored value.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `we`, input, 1: register write enable (RegWrite).
- `ra1`, input, 5: read address 1 (rs).
- `ra2`, input, 5: read address 2 (rt).
- `wa`, input, 5: write address, from `Reg_MUX` output.
- `wd`, input, WIDTH: write data, from `Memtoreg` output.
- `pc`, input, 32: PC of the instruction performing the write. Used only for the trace.
- `rd1`, output, WIDTH: read data 1.
- `rd2`, output, WIDTH: read data 2.
- `wcnt`, output, 32: count of committed writes.

## Operation

- Storage is 32 registers × WIDTH, indexed 0–31. Register 0 reads as 0 at all times and is never written.
- Reset, with `reset`=1 at a rising edge:
  - All 32 registers clear to 0.
  - `wcnt` clears to 0.
  - `we` is ignored in that cycle. No write is performed and no trace line is printed.
- Write, at a rising edge with `reset`=0, `we`=1 and `wa`≠0:
  - `regs[wa]` ← `wd`.
  - `wcnt` ← `wcnt`+1. The counter wraps from 0xFFFFFFFF to 0.
  - Print exactly one line: `@%h: $%d <= %h` with `pc`, `wa`, `wd`, in decimal-padded `$display` format.
- Write to `$0`, with `we`=1 and `wa`=0:
  - No state change.
  - `wcnt` does not increment.
  - No trace line is printed.
- `we`=0: no state change, whatever `wa` and `wd` are.
- Reads are combinational. For each port n:
  - `rdn` = 0 if `ran`=0.
  - Otherwise, if BYPASS=1 and `we`=1 and `reset`=0 and `wa`=`ran`, then `rdn` = `wd`.
  - Otherwise `rdn` = `regs[ran]`.
- Both read ports are independent. `ra1`=`ra2` is legal, and both ports return the same value.
- A write has no effect on any register other than `regs[wa]`.

## Timing

- Read latency is 0 cycles, combinational from `ra*`, `regs`, and, when BYPASS=1, from `we`/`wa`/`wd`.
- Write latency is 1 edge. With BYPASS=0, the new value is visible on `rd*` immediately after the capturing edge. With BYPASS=1, it is already visible before that edge.
- Reset mid-stream: a `reset`=1 edge overrides a simultaneous write. After that edge every `rd*`=0 and `wcnt`=0.
- Output values after reset: `rd1`=`rd2`=0 for any address, and `wcnt`=0.
- No X propagation from storage: all registers are defined after the first reset edge. Before the first reset, the contents are don't-care.
- The trace is printed in the same always block as the write, so it appears once per committed write, on the capturing edge.

## Test plan

1. **Reset clear.** Write 0xDEADBEEF to $5, then apply `reset`=1 for 1 edge. Expect rd1(ra1=5)=0 and `wcnt`=0. Also assert `reset` and `we` together with `wa`=6, `wd`=1: $6 must stay 0 and no trace line is printed.
2. **Basic write/read.** `we`=1, `wa`=8, `wd`=0x12345678, `pc`=0x00003000, 1 edge. Then ra1=8 and ra2=8 both read 0x12345678. `wcnt`=1. The trace line reads `@00003000: $ 8 <= 12345678`.
3. **$0 immutability.** `we`=1, `wa`=0, `wd`=0xFFFFFFFF, 1 edge. Then rd1(ra1=0)=0 and `wcnt` is unchanged. Same-cycle bypass is also checked: rd1 with ra1=0 stays 0.
4. **Bypass.** With BYPASS=1 and $9 holding 0x11: set `we`=1, `wa`=9, `wd`=0x22, ra1=9 before the edge. rd1 must be 0x22 combinationally. With BYPASS=0 under the same stimulus, rd1=0x11 before the edge and 0x22 after it.
5. **Full sweep with independence.** Write i×0x01010101 to $i for i=1..31, 31 edges. Read all pairs (ra1=i, ra2=31−i) and each must match. Expect `wcnt`=31. A subsequent `we`=0 cycle with `wa`=3, `wd`=0 leaves $3 at 0x03030303.
6. **jal write-back.** Drive `wa`=31, `wd`=`pc`+4=0x00003008, `pc`=0x00003004, `we`=1. After the edge $31=0x00003008, and $30 is unchanged.
